cronometro_param: RTL and testbench



---
 rtl/cronometro_param.sv | 241 ++++++++++++++++++++++++
 tb/tb_cronometro_param.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cronometro_param.sv
// -----------------------------------------------------------------------------
// cronometro_param
//
// Parametrised seconds stopwatch / countdown timer driving an N-digit
// multiplexed 7-segment display.
//
// The count is a binary value held in 0..MAX_COUNT (MAX_COUNT = 10^N_DIGITS-1).
// Up mode wraps MAX_COUNT -> 0. Down mode stops at 0. Both terminal transitions
// raise a one-cycle pulse on `fim`. The value can be loaded from `chaves`, and
// loads are clamped to MAX_COUNT.
//
// Parameters:
//   CLOCK_FREQ  clock cycles per one-second tick (>= 2)
//   N_DIGITS    displayed decimal digits, 1..4
//   LOAD_W      width of chaves
//   SCAN_DIV    clock cycles per display digit slot (>= 1)
//
// Ports:
//   clock    in   system clock, rising edge
//   reset    in   synchronous, active-high reset
//   carga    in   load value from chaves (level, overrides conta)
//   conta    in   count enable (level)
//   modo     in   0 = count up, 1 = count down
//   chaves   in   binary load value [LOAD_W-1:0]
//   an       out  digit anodes, active-low one-hot [N_DIGITS-1:0]
//   dec_ddp  out  [7:1] segments a..g, [0] decimal point; all active-low
//   fim      out  one-cycle terminal-event pulse
//
// Optional build macro:
//   CRONOMETRO_ZERO_BLANK_EN  blanks leading-zero digits (digit 0 always shown)
// -----------------------------------------------------------------------------
module cronometro_param #(
    parameter int unsigned CLOCK_FREQ = 100000000,
    parameter int unsigned N_DIGITS   = 4,
    parameter int unsigned LOAD_W     = 7,
    parameter int unsigned SCAN_DIV   = 100000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                carga,
    input  logic                conta,
    input  logic                modo,
    input  logic [LOAD_W-1:0]   chaves,
    output logic [N_DIGITS-1:0] an,
    output logic [7:0]          dec_ddp,
    output logic                fim
);

    // -------------------------------------------------------------------------
    // Derived constants
    // -------------------------------------------------------------------------
    localparam int unsigned MAX_COUNT = (N_DIGITS == 1) ? 9   :
                                        (N_DIGITS == 2) ? 99  :
                                        (N_DIGITS == 3) ? 999 : 9999;

    localparam int unsigned PRE_W  = $clog2(CLOCK_FREQ);
    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    // Width wide enough to compare chaves against MAX_COUNT without truncation.
    localparam int unsigned CMP_W  = (LOAD_W > 14) ? LOAD_W : 14;

    localparam logic [13:0]         MAX_V     = 14'(MAX_COUNT);
    localparam logic [CMP_W-1:0]    MAX_CMP   = CMP_W'(MAX_COUNT);
    localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(CLOCK_FREQ - 1);
    localparam logic [PRE_W-1:0]    PRE_ONE   = PRE_W'(1);
    localparam logic [SCAN_W-1:0]   SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [SCAN_W-1:0]   SCAN_ONE  = SCAN_W'(1);
    localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(N_DIGITS - 1);
    localparam logic [IDX_W-1:0]    IDX_ONE   = IDX_W'(1);
    localparam logic [N_DIGITS-1:0] AN_ONE    = N_DIGITS'(1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [13:0]       value_q;
    logic [PRE_W-1:0]  presc_q;
    logic [SCAN_W-1:0] scan_q;
    logic [IDX_W-1:0]  idx_q;

    // -------------------------------------------------------------------------
    // Load clamp
    // -------------------------------------------------------------------------
    logic [CMP_W-1:0] chaves_ext;
    logic [13:0]      load_val;

    always_comb begin
        chaves_ext = CMP_W'(chaves);
        if (chaves_ext > MAX_CMP) begin
            load_val = MAX_V;
        end else begin
            load_val = 14'(chaves_ext);
        end
    end

    // -------------------------------------------------------------------------
    // One-second tick and next count value
    // -------------------------------------------------------------------------
    logic        tick;
    logic [13:0] value_nxt;
    logic        terminal;

    assign tick = (presc_q == PRE_LAST);

    always_comb begin
        value_nxt = value_q;
        terminal  = 1'b0;
        if (!modo) begin
            if (value_q == MAX_V) begin
                value_nxt = 14'd0;
                terminal  = 1'b1;
            end else begin
                value_nxt = value_q + 14'd1;
            end
        end else begin
            if (value_q > 14'd1) begin
                value_nxt = value_q - 14'd1;
            end else if (value_q == 14'd1) begin
                value_nxt = 14'd0;
                terminal  = 1'b1;
            end
            // value_q == 0 in down mode: the tick is ignored.
        end
    end

    // -------------------------------------------------------------------------
    // Counter, prescaler and terminal pulse
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            value_q <= 14'd0;
            presc_q <= '0;
            fim     <= 1'b0;
        end else if (carga) begin
            value_q <= load_val;
            presc_q <= '0;
            fim     <= 1'b0;
        end else if (conta) begin
            if (tick) begin
                presc_q <= '0;
                value_q <= value_nxt;
                fim     <= terminal;
            end else begin
                presc_q <= presc_q + PRE_ONE;
                fim     <= 1'b0;
            end
        end else begin
            // Paused: prescaler holds so the partial second survives resume.
            fim <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Digit scan, free-running regardless of conta/carga
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            scan_q <= '0;
            idx_q  <= '0;
        end else if (scan_q == SCAN_LAST) begin
            scan_q <= '0;
            if (idx_q == IDX_LAST) begin
                idx_q <= '0;
            end else begin
                idx_q <= idx_q + IDX_ONE;
            end
        end else begin
            scan_q <= scan_q + SCAN_ONE;
        end
    end

    // -------------------------------------------------------------------------
    // Binary to BCD (shift-and-add-3). value_q <= 9999 so four digits suffice.
    // -------------------------------------------------------------------------
    logic [15:0] bcd;

    always_comb begin
        bcd = 16'd0;
        for (int i = 13; i >= 0; i--) begin
            for (int d = 0; d < 4; d++) begin
                if (bcd[d*4 +: 4] >= 4'd5) begin
                    bcd[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
                end
            end
            bcd = {bcd[14:0], value_q[i]};
        end
    end

    // -------------------------------------------------------------------------
    // Digit select, segment decode, decimal point
    // -------------------------------------------------------------------------
    logic [15:0] bcd_sh;
    logic [3:0]  digit;
    logic [6:0]  seg_dec;
    logic [6:0]  seg;
    logic        blank;
    logic        dp;

    assign bcd_sh = bcd >> {idx_q, 2'b00};
    assign digit  = bcd_sh[3:0];

`ifdef CRONOMETRO_ZERO_BLANK_EN
    // Leading zero: this digit and every more significant one are zero.
    assign blank = (idx_q != '0) && (bcd_sh == 16'd0);
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        case (digit)
            4'd0:    seg_dec = 7'b0000001;
            4'd1:    seg_dec = 7'b1001111;
            4'd2:    seg_dec = 7'b0010010;
            4'd3:    seg_dec = 7'b0000110;
            4'd4:    seg_dec = 7'b1001100;
            4'd5:    seg_dec = 7'b0100100;
            4'd6:    seg_dec = 7'b0100000;
            4'd7:    seg_dec = 7'b0001111;
            4'd8:    seg_dec = 7'b0000000;
            4'd9:    seg_dec = 7'b0000100;
            default: seg_dec = 7'b1111111;
        endcase
        seg = blank ? 7'b1111111 : seg_dec;
    end

    // Decimal point marks "running" on the least significant digit.
    assign dp = ~(conta && !carga && (idx_q == '0));

    // -------------------------------------------------------------------------
    // Registered display outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            an      <= ~AN_ONE;
            dec_ddp <= 8'b0000_0011;
        end else begin
            an      <= ~(AN_ONE << idx_q);
            dec_ddp <= {seg, dp};
        end
    end

endmodule

// File: tb/tb_cronometro_param.sv
module tb_cronometro_param;

    localparam int CF = 4;
    localparam int SD = 2;

    logic       clock = 1'b0;
    logic       reset, carga, conta, modo;
    logic [6:0] chaves;
    logic [3:0] an4;
    logic [7:0] dec4;
    logic       fim4;
    logic [1:0] an2;
    logic [7:0] dec2;
    logic       fim2;

    always #5 clock = ~clock;

    cronometro_param #(.CLOCK_FREQ(CF), .N_DIGITS(4), .LOAD_W(7), .SCAN_DIV(SD)) dut4 (
        .clock(clock), .reset(reset), .carga(carga), .conta(conta), .modo(modo),
        .chaves(chaves), .an(an4), .dec_ddp(dec4), .fim(fim4)
    );

    cronometro_param #(.CLOCK_FREQ(CF), .N_DIGITS(2), .LOAD_W(7), .SCAN_DIV(SD)) dut2 (
        .clock(clock), .reset(reset), .carga(carga), .conta(conta), .modo(modo),
        .chaves(chaves), .an(an2), .dec_ddp(dec2), .fim(fim2)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: index 0 = 4-digit instance, index 1 = 2-digit instance.
    int         nd[2] = '{4, 2};
    int         mx[2] = '{9999, 99};
    int         m_val[2];
    int         m_pre[2];
    int         m_cyc[2];
    logic       m_fim[2];
    logic [7:0] m_dec[2];
    logic [3:0] m_an[2];
    logic [6:0] seg_tab[10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                7'b0000000, 7'b0000100};

    function automatic int pow10(input int k);
        int r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            int         k;
            int         dig;
            logic [6:0] s;
            if (reset) begin
                m_val[d] = 0;
                m_pre[d] = 0;
                m_cyc[d] = 0;
                m_fim[d] = 1'b0;
                m_an[d]  = 4'b1110;
                m_dec[d] = 8'b0000_0011;
            end else begin
                // Display reflects state before this edge.
                k   = (m_cyc[d] / SD) % nd[d];
                dig = (m_val[d] / pow10(k)) % 10;
                s   = seg_tab[dig];
`ifdef CRONOMETRO_ZERO_BLANK_EN
                if (k > 0 && m_val[d] < pow10(k)) s = 7'b1111111;
`endif
                m_dec[d] = {s, ~(conta && !carga && k == 0)};
                m_an[d]  = ~(4'b0001 << k);
                m_cyc[d]++;
                if (carga) begin
                    m_val[d] = (int'(chaves) > mx[d]) ? mx[d] : int'(chaves);
                    m_pre[d] = 0;
                    m_fim[d] = 1'b0;
                end else if (conta) begin
                    m_fim[d] = 1'b0;
                    if (m_pre[d] == CF - 1) begin
                        m_pre[d] = 0;
                        if (!modo) begin
                            if (m_val[d] == mx[d]) begin
                                m_val[d] = 0;
                                m_fim[d] = 1'b1;
                            end else begin
                                m_val[d]++;
                            end
                        end else if (m_val[d] == 1) begin
                            m_val[d] = 0;
                            m_fim[d] = 1'b1;
                        end else if (m_val[d] > 1) begin
                            m_val[d]--;
                        end
                    end else begin
                        m_pre[d]++;
                    end
                end else begin
                    m_fim[d] = 1'b0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_step();
        #1;
        check("an4",  an4,  m_an[0]);
        check("dec4", dec4, m_dec[0]);
        check("fim4", fim4, m_fim[0]);
        check("an2",  an2,  m_an[1][1:0]);
        check("dec2", dec2, m_dec[1]);
        check("fim2", fim2, m_fim[1]);
    endtask

    typedef struct {
        logic       rst;
        logic       ld;
        logic       cnt;
        logic       md;
        logic [6:0] ch;
        int         n;
        int         val;
        logic       f;
    } vec_t;

    vec_t       tbl[24];
    logic [3:0] an_seq[8];

    initial begin
        // rst ld cnt md ch n val fim  (expected 4-digit value and fim after n cycles)
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 7'd5, 1,  5,  1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 7'd5, 4,  6,  1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 7'd5, 4,  7,  1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 7'd5, 4,  8,  1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 7'd5, 3,  8,  1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 7'd2, 1,  2,  1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 7'd2, 4,  1,  1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 7'd2, 3,  1,  1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 7'd2, 1,  0,  1'b1};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 7'd2, 1,  0,  1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 7'd2, 8,  0,  1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 7'd7, 1,  7,  1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 7'd7, 2,  7,  1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 7'd7, 5,  7,  1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 7'd7, 2,  8,  1'b0};
        tbl[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 7'd9, 10, 9,  1'b0};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 7'd9, 3,  9,  1'b0};
        tbl[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 7'd9, 1,  10, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 1'b1, 1'b0, 7'd9, 2,  10, 1'b0};
        tbl[19] = '{1'b1, 1'b1, 1'b1, 1'b0, 7'd9, 1,  0,  1'b0};
        tbl[20] = '{1'b0, 1'b0, 1'b1, 1'b0, 7'd9, 3,  0,  1'b0};
        tbl[21] = '{1'b0, 1'b0, 1'b1, 1'b0, 7'd9, 1,  1,  1'b0};
        tbl[22] = '{1'b0, 1'b0, 1'b1, 1'b1, 7'd9, 2,  1,  1'b0};
        tbl[23] = '{1'b0, 1'b0, 1'b1, 1'b1, 7'd9, 2,  0,  1'b1};

        an_seq = '{4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1011, 4'b1011, 4'b0111, 4'b0111};

        // Reset held for 5 cycles.
        reset  = 1'b1;
        carga  = 1'b0;
        conta  = 1'b0;
        modo   = 1'b0;
        chaves = 7'd0;
        repeat (5) step();
        check("rst_fim", fim4, 0);
        check("rst_an",  an4,  4'b1110);
        check("rst_dec", dec4, 8'b0000_0011);

        // Anode scan after release.
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("an_seq%0d", i), an4, an_seq[i]);
        end

        // Directed vector table.
        for (int i = 0; i < 24; i++) begin
            reset  = tbl[i].rst;
            carga  = tbl[i].ld;
            conta  = tbl[i].cnt;
            modo   = tbl[i].md;
            chaves = tbl[i].ch;
            repeat (tbl[i].n) step();
            check($sformatf("vec%0d_val", i), dut4.value_q, tbl[i].val);
            check($sformatf("vec%0d_fim", i), fim4, tbl[i].f);
        end

        // Saturation on the 2-digit instance, then wrap 99 -> 0.
        carga  = 1'b1;
        conta  = 1'b0;
        modo   = 1'b0;
        chaves = 7'd100;
        step();
        check("sat2_val", dut2.value_q, 99);
        check("sat4_val", dut4.value_q, 100);
        carga = 1'b0;
        conta = 1'b1;
        repeat (3) step();
        check("wrap_pre_fim", fim2, 0);
        step();
        check("wrap_val", dut2.value_q, 0);
        check("wrap_fim", fim2, 1);
        step();
        check("wrap_fim_end", fim2, 0);
        check("wrap4_val", dut4.value_q, 101);

        // Randomised run against the model.
        for (int i = 0; i < 3000; i++) begin
            reset  = ($urandom_range(0, 199) == 0);
            carga  = ($urandom_range(0, 39) == 0);
            conta  = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 49) == 0) modo = ~modo;
            chaves = 7'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
